pad_mux: RTL and testbench

PAD_MUX -- requirements
Module: pad_mux

---
 rtl/pad_mux_pkg.sv | 21 ++
 rtl/pad_mux_filter.sv | 46 ++++
 rtl/pad_mux.sv | 174 +++++++++++++++++
 tb/tb_pad_mux.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_mux_pkg.sv
// Shared register map, field widths and select helper for the pad multiplexer.
package pad_mux_pkg;

    localparam int unsigned CfgAddrW  = 8;
    localparam int unsigned CfgDataW  = 32;
    localparam int unsigned SelW      = 7;
    localparam int unsigned FiltEnBit = 8;

    typedef enum logic [CfgAddrW-1:0] {
        REG_OUTSEL_BASE = 8'h00,
        REG_INSEL_BASE  = 8'h80,
        REG_FILT_THRESH = 8'hFE,
        REG_LOCK        = 8'hFF
    } reg_offset_e;

    // Selects are 1-based so that 0 always means "nothing connected".
    function automatic logic sel_hits(input logic [SelW-1:0] sel, input int unsigned idx);
        return 32'(sel) == idx + 32'd1;
    endfunction

endpackage

// File: rtl/pad_mux_filter.sv
// Per-pad input path: two-flop synchroniser followed by a glitch-filter register.
module pad_mux_filter
    import pad_mux_pkg::*;
#(
    parameter int unsigned FiltW = 4
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_i,
    input  logic             pad_i,
    input  logic             filt_on_i,
    input  logic [FiltW-1:0] thresh_i,
    output logic             filt_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             filt_q;
    logic [FiltW-1:0] cnt_q;

    // A new level is accepted only after it has persisted past the threshold.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
            if (!filt_on_i) begin
                filt_q <= sync2_q;
                cnt_q  <= '0;
            end else if (sync2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q >= thresh_i) begin
                filt_q <= sync2_q;
                cnt_q  <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + FiltW'(1);
            end
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/pad_mux.sv
// Configurable pad multiplexer: routes peripheral outputs to pads and
// filtered pad inputs back to peripherals under a small register file.
module pad_mux
    import pad_mux_pkg::*;
#(
    parameter int unsigned          NPads      = 70,
    parameter int unsigned          NPeriphOut = 64,
    parameter int unsigned          NPeriphIn  = 32,
    parameter int unsigned          FiltW      = 4,
    parameter logic [NPeriphIn-1:0] InDefault  = '0
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_sys_i,
    input  logic                  cfg_req_i,
    input  logic                  cfg_we_i,
    input  logic [CfgAddrW-1:0]   cfg_addr_i,
    input  logic [CfgDataW-1:0]   cfg_wdata_i,
    output logic [CfgDataW-1:0]   cfg_rdata_o,
    output logic                  cfg_rvalid_o,
    input  logic [NPeriphOut-1:0] periph_out_i,
    input  logic [NPeriphOut-1:0] periph_oe_i,
    output logic [NPeriphIn-1:0]  periph_in_o,
    input  logic [NPads-1:0]      pad_in_i,
    output logic [NPads-1:0]      pad_out_o,
    output logic [NPads-1:0]      pad_oe_o
);

    logic [SelW-1:0]      outsel_q [NPads];
    logic [SelW-1:0]      insel_q  [NPeriphIn];
    logic [NPeriphIn-1:0] filt_en_q;
    logic [FiltW-1:0]     thresh_q;
    logic                 lock_q;

    logic [CfgDataW-1:0]  rdata_c;
    logic                 cfg_wr_c;
    logic [NPads-1:0]     pad_out_c;
    logic [NPads-1:0]     pad_oe_c;
    logic [NPads-1:0]     filt_on_c;
    logic [NPads-1:0]     filt_val;
    logic                 unused_wdata;

    assign cfg_wr_c     = cfg_req_i && cfg_we_i && !lock_q;
    assign unused_wdata = ^{cfg_wdata_i[CfgDataW-1:FiltEnBit+1], cfg_wdata_i[FiltEnBit-1:SelW]};

    // Read mux; sampled on acceptance so a same-cycle write returns the old value.
    always_comb begin
        rdata_c = '0;
        for (int unsigned p = 0; p < NPads; p++) begin
            if (cfg_addr_i == 8'(REG_OUTSEL_BASE) + 8'(p)) begin
                rdata_c = 32'(outsel_q[p]);
            end
        end
        for (int unsigned i = 0; i < NPeriphIn; i++) begin
            if (cfg_addr_i == 8'(REG_INSEL_BASE) + 8'(i)) begin
                rdata_c = 32'({filt_en_q[i], 1'b0, insel_q[i]});
            end
        end
        if (cfg_addr_i == REG_FILT_THRESH) begin
            rdata_c = 32'(thresh_q);
        end
        if (cfg_addr_i == REG_LOCK) begin
            rdata_c = 32'(lock_q);
        end
    end

    // Configuration registers; LOCK freezes everything until reset.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            for (int unsigned p = 0; p < NPads; p++) begin
                outsel_q[p] <= '0;
            end
            for (int unsigned i = 0; i < NPeriphIn; i++) begin
                insel_q[i] <= '0;
            end
            filt_en_q <= '0;
            thresh_q  <= '0;
            lock_q    <= 1'b0;
        end else if (cfg_wr_c) begin
            for (int unsigned p = 0; p < NPads; p++) begin
                if (cfg_addr_i == 8'(REG_OUTSEL_BASE) + 8'(p)) begin
                    outsel_q[p] <= cfg_wdata_i[SelW-1:0];
                end
            end
            for (int unsigned i = 0; i < NPeriphIn; i++) begin
                if (cfg_addr_i == 8'(REG_INSEL_BASE) + 8'(i)) begin
                    insel_q[i]   <= cfg_wdata_i[SelW-1:0];
                    filt_en_q[i] <= cfg_wdata_i[FiltEnBit];
                end
            end
            if (cfg_addr_i == REG_FILT_THRESH) begin
                thresh_q <= cfg_wdata_i[FiltW-1:0];
            end
            if (cfg_addr_i == REG_LOCK) begin
                lock_q <= cfg_wdata_i[0];
            end
        end
    end

    // Response channel: every request answers exactly one cycle later.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o  <= '0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            if (cfg_req_i) begin
                cfg_rdata_o <= rdata_c;
            end
        end
    end

    always_comb begin
        pad_out_c = '0;
        pad_oe_c  = '0;
        for (int unsigned p = 0; p < NPads; p++) begin
            for (int unsigned j = 0; j < NPeriphOut; j++) begin
                if (sel_hits(outsel_q[p], j)) begin
                    pad_out_c[p] = periph_out_i[j];
                    pad_oe_c[p]  = periph_oe_i[j];
                end
            end
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            pad_out_o <= '0;
            pad_oe_o  <= '0;
        end else begin
            pad_out_o <= pad_out_c;
            pad_oe_o  <= pad_oe_c;
        end
    end

    // A pad is filtered if any filtered input listens to it and a threshold is set.
    always_comb begin
        filt_on_c = '0;
        for (int unsigned p = 0; p < NPads; p++) begin
            for (int unsigned i = 0; i < NPeriphIn; i++) begin
                if (filt_en_q[i] && sel_hits(insel_q[i], p)) begin
                    filt_on_c[p] = 1'b1;
                end
            end
        end
        if (thresh_q == '0) begin
            filt_on_c = '0;
        end
    end

    for (genvar p = 0; p < NPads; p++) begin : g_pad
        pad_mux_filter #(
            .FiltW(FiltW)
        ) u_filter (
            .clk_sys_i(clk_sys_i),
            .rst_sys_i(rst_sys_i),
            .pad_i    (pad_in_i[p]),
            .filt_on_i(filt_on_c[p]),
            .thresh_i (thresh_q),
            .filt_o   (filt_val[p])
        );
    end

    always_comb begin
        periph_in_o = InDefault;
        for (int unsigned i = 0; i < NPeriphIn; i++) begin
            for (int unsigned p = 0; p < NPads; p++) begin
                if (sel_hits(insel_q[i], p)) begin
                    periph_in_o[i] = filt_val[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_pad_mux.sv
// Self-checking bench for pad_mux against a register-map and timing model.
module tb_pad_mux;

    localparam int unsigned NPads  = 70;
    localparam int unsigned NOut   = 64;
    localparam int unsigned NIn    = 32;
    localparam logic [31:0] IN_DEF = 32'h8000_0012;

    logic              clk;
    logic              rst;
    logic              cfg_req;
    logic              cfg_we;
    logic [7:0]        cfg_addr;
    logic [31:0]       cfg_wdata;
    logic [31:0]       cfg_rdata;
    logic              cfg_rvalid;
    logic [NOut-1:0]   periph_out;
    logic [NOut-1:0]   periph_oe;
    logic [NIn-1:0]    periph_in;
    logic [NPads-1:0]  pad_in;
    logic [NPads-1:0]  pad_out;
    logic [NPads-1:0]  pad_oe;

    int errors;
    int checks;

    int unsigned m_outsel [NPads];
    int unsigned m_insel  [NIn];
    logic        m_filten [NIn];
    int unsigned m_thresh;
    logic        m_lock;

    pad_mux #(
        .NPads     (NPads),
        .NPeriphOut(NOut),
        .NPeriphIn (NIn),
        .FiltW     (4),
        .InDefault (IN_DEF)
    ) dut (
        .clk_sys_i   (clk),
        .rst_sys_i   (rst),
        .cfg_req_i   (cfg_req),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .cfg_rdata_o (cfg_rdata),
        .cfg_rvalid_o(cfg_rvalid),
        .periph_out_i(periph_out),
        .periph_oe_i (periph_oe),
        .periph_in_o (periph_in),
        .pad_in_i    (pad_in),
        .pad_out_o   (pad_out),
        .pad_oe_o    (pad_oe)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int p = 0; p < NPads; p++) m_outsel[p] = 0;
        for (int i = 0; i < NIn; i++) begin
            m_insel[i]  = 0;
            m_filten[i] = 1'b0;
        end
        m_thresh = 0;
        m_lock   = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int unsigned ai = 32'(a);
        if (ai < NPads) return 32'(m_outsel[ai]);
        if (ai >= 128 && ai < 128 + NIn)
            return {23'd0, m_filten[ai-128], 1'b0, 7'(m_insel[ai-128])};
        if (ai == 254) return 32'(m_thresh);
        if (ai == 255) return {31'd0, m_lock};
        return 32'd0;
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [31:0] d);
        int unsigned ai = 32'(a);
        if (m_lock) return;
        if (ai < NPads) m_outsel[ai] = 32'(d[6:0]);
        if (ai >= 128 && ai < 128 + NIn) begin
            m_insel[ai-128]  = 32'(d[6:0]);
            m_filten[ai-128] = d[8];
        end
        if (ai == 254) m_thresh = 32'(d[3:0]);
        if (ai == 255) m_lock = d[0];
    endfunction

    function automatic logic [NPads-1:0] exp_pad(input logic [NOut-1:0] v);
        logic [NPads-1:0] r = '0;
        for (int p = 0; p < NPads; p++)
            if (m_outsel[p] >= 1 && m_outsel[p] <= NOut) r[p] = v[m_outsel[p]-1];
        return r;
    endfunction

    function automatic logic [NIn-1:0] exp_in(input logic [NPads-1:0] padv);
        logic [NIn-1:0] r = IN_DEF;
        for (int i = 0; i < NIn; i++)
            if (m_insel[i] >= 1 && m_insel[i] <= NPads) r[i] = padv[m_insel[i]-1];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] old;
        old       = model_read(a);
        cfg_req   = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_req = 1'b0;
        cfg_we  = 1'b0;
        checks++;
        if (cfg_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL wr_rvalid addr=%02h got=%b exp=1", a, cfg_rvalid);
        end
        checks++;
        if (cfg_rdata !== old) begin
            errors++;
            $display("FAIL wr_old_rdata addr=%02h got=%08h exp=%08h", a, cfg_rdata, old);
        end
        model_write(a, d);
    endtask

    task automatic cfg_read(input logic [7:0] a);
        logic [31:0] expv;
        expv     = model_read(a);
        cfg_req  = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = a;
        step();
        cfg_req = 1'b0;
        checks++;
        if (cfg_rvalid !== 1'b1 || cfg_rdata !== expv) begin
            errors++;
            $display("FAIL rd addr=%02h got=%08h/v%b exp=%08h/v1", a, cfg_rdata, cfg_rvalid, expv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (pad_out !== '0 || pad_oe !== '0) begin
            errors++;
            $display("FAIL reset_pads got=%h/%h exp=0/0", pad_out, pad_oe);
        end
        checks++;
        if (cfg_rvalid !== 1'b0 || cfg_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_cfg got=%08h/v%b exp=0/v0", cfg_rdata, cfg_rvalid);
        end
        checks++;
        if (periph_in !== IN_DEF) begin
            errors++;
            $display("FAIL reset_periph_in got=%08h exp=%08h", periph_in, IN_DEF);
        end
        rst = 1'b0;
        model_clear();
        step();
        cfg_read(8'h05);
        cfg_read(8'h80);
        cfg_read(8'hFE);
        cfg_read(8'hFF);
    endtask

    task automatic test_outsel_basic();
        periph_out    = '0;
        periph_oe     = '0;
        periph_out[2] = 1'b1;
        periph_oe[2]  = 1'b1;
        cfg_write(8'h05, 32'd3);
        checks++;
        if (pad_out[5] !== 1'b0) begin
            errors++;
            $display("FAIL outsel_early got=%b exp=0", pad_out[5]);
        end
        step();
        checks++;
        if (pad_out[5] !== 1'b1 || pad_oe[5] !== 1'b1) begin
            errors++;
            $display("FAIL outsel_basic got=%b/%b exp=1/1", pad_out[5], pad_oe[5]);
        end
        cfg_read(8'h05);
    endtask

    task automatic test_back_to_back();
        periph_out = '1;
        periph_oe  = '1;
        cfg_write(8'h06, 32'hFFFF_FF45);
        cfg_read(8'h06);
        cfg_write(8'h50, 32'd9);
        cfg_read(8'h50);
        cfg_write(8'hA0, 32'd9);
        cfg_read(8'hA0);
        cfg_read(8'hC0);
        step();
        checks++;
        if (cfg_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_drop got=%b exp=0", cfg_rvalid);
        end
        checks++;
        if (pad_out[6] !== 1'b0 || pad_oe[6] !== 1'b0) begin
            errors++;
            $display("FAIL outsel_over_range got=%b/%b exp=0/0", pad_out[6], pad_oe[6]);
        end
    endtask

    task automatic test_outsel_random();
        for (int it = 0; it < 25; it++) begin
            int unsigned p;
            int unsigned sel;
            p   = $urandom_range(0, NPads - 1);
            sel = $urandom_range(0, 127);
            cfg_write(8'(p), ($urandom() & 32'hFFFF_FF80) | sel);
            periph_out = {$urandom(), $urandom()};
            periph_oe  = {$urandom(), $urandom()};
            step();
            checks++;
            if (pad_out !== exp_pad(periph_out) || pad_oe !== exp_pad(periph_oe)) begin
                errors++;
                $display("FAIL outsel_rand it=%0d got=%h/%h exp=%h/%h", it, pad_out, pad_oe,
                         exp_pad(periph_out), exp_pad(periph_oe));
            end
            if (it % 5 == 0) cfg_read(8'(p));
        end
    endtask

    task automatic test_insel_unfiltered();
        pad_in = '0;
        cfg_write(8'h80, 32'd11);
        repeat (4) step();
        pad_in[10] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (periph_in[0] !== (k == 3)) begin
                errors++;
                $display("FAIL insel_latency k=%0d got=%b exp=%b", k, periph_in[0], k == 3);
            end
        end
    endtask

    task automatic test_input_random();
        logic [NPads-1:0] hist[$];
        for (int i = 0; i < NIn; i++)
            cfg_write(8'(32'h80 + i), ($urandom() & 32'h100) | $urandom_range(0, 80));
        for (int c = 0; c < 40; c++) begin
            pad_in = 70'({$urandom(), $urandom(), $urandom()});
            step();
            hist.push_back(pad_in);
            if (hist.size() >= 3) begin
                checks++;
                if (periph_in !== exp_in(hist[hist.size()-3])) begin
                    errors++;
                    $display("FAIL input_rand c=%0d got=%08h exp=%08h", c, periph_in,
                             exp_in(hist[hist.size()-3]));
                end
            end
        end
    endtask

    task automatic filter_pulse(input int len, input int thr);
        logic expb;
        pad_in[10] = 1'b0;
        repeat (thr + 6) step();
        checks++;
        if (periph_in[0] !== 1'b0) begin
            errors++;
            $display("FAIL filt_idle len=%0d thr=%0d got=%b exp=0", len, thr, periph_in[0]);
        end
        for (int k = 1; k <= len + thr + 6; k++) begin
            pad_in[10] = (k <= len);
            step();
            expb = (len >= thr + 1) && (k >= 3 + thr) && (k <= len + 2 + thr);
            checks++;
            if (periph_in[0] !== expb) begin
                errors++;
                $display("FAIL filt_pulse len=%0d thr=%0d k=%0d got=%b exp=%b",
                         len, thr, k, periph_in[0], expb);
            end
        end
    endtask

    task automatic test_filter();
        int thr;
        pad_in = '0;
        for (int i = 1; i < NIn; i++) cfg_write(8'(32'h80 + i), 32'd0);
        cfg_write(8'h80, 32'h10B);
        cfg_write(8'hFE, 32'hFFFF_FFF4);
        cfg_read(8'h80);
        cfg_read(8'hFE);
        filter_pulse(3, 4);
        filter_pulse(6, 4);
        filter_pulse(4, 4);
        filter_pulse(5, 4);
        for (int it = 0; it < 6; it++) begin
            thr = $urandom_range(0, 6);
            cfg_write(8'hFE, ($urandom() & 32'hFFFF_FFF0) | 32'(thr));
            filter_pulse($urandom_range(1, 9), thr);
        end
        cfg_write(8'hFE, 32'd4);
        cfg_write(8'h80, 32'd11);
        filter_pulse(2, 0);
    endtask

    task automatic test_default();
        cfg_write(8'h81, 32'd0);
        for (int c = 0; c < 5; c++) begin
            pad_in = 70'({$urandom(), $urandom(), $urandom()});
            step();
            checks++;
            if (periph_in[1] !== 1'b1) begin
                errors++;
                $display("FAIL default_sel0 c=%0d got=%b exp=1", c, periph_in[1]);
            end
        end
        cfg_write(8'h81, 32'd200);
        cfg_read(8'h81);
        for (int c = 0; c < 5; c++) begin
            pad_in = 70'({$urandom(), $urandom(), $urandom()});
            step();
            checks++;
            if (periph_in[1] !== 1'b1) begin
                errors++;
                $display("FAIL default_sel200 c=%0d got=%b exp=1", c, periph_in[1]);
            end
        end
    endtask

    task automatic test_lock();
        periph_out    = {$urandom(), $urandom()};
        periph_oe     = {$urandom(), $urandom()};
        periph_out[2] = 1'b1;
        periph_oe[2]  = 1'b1;
        cfg_write(8'h05, 32'd3);
        cfg_write(8'hFF, 32'd1);
        cfg_write(8'h05, 32'd7);
        cfg_read(8'h05);
        step();
        checks++;
        if (pad_out !== exp_pad(periph_out) || pad_out[5] !== 1'b1 || pad_oe[5] !== 1'b1) begin
            errors++;
            $display("FAIL lock_pads got=%h exp=%h", pad_out, exp_pad(periph_out));
        end
        cfg_write(8'hFF, 32'd0);
        cfg_read(8'hFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        step();
        cfg_read(8'h05);
        cfg_read(8'hFF);
        cfg_write(8'h05, 32'd3);
        cfg_read(8'h05);
    endtask

    task automatic test_reset_abort();
        step();
        checks++;
        if (pad_out[5] !== 1'b1) begin
            errors++;
            $display("FAIL abort_precond got=%b exp=1", pad_out[5]);
        end
        cfg_req  = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = 8'h05;
        #3;
        rst = 1'b1;
        step();
        cfg_req = 1'b0;
        checks++;
        if (cfg_rvalid !== 1'b0 || cfg_rdata !== 32'd0) begin
            errors++;
            $display("FAIL abort_rvalid got=%08h/v%b exp=0/v0", cfg_rdata, cfg_rvalid);
        end
        checks++;
        if (pad_out !== '0 || pad_oe !== '0 || periph_in !== IN_DEF) begin
            errors++;
            $display("FAIL abort_outputs got=%h/%h/%08h exp=0/0/%08h", pad_out, pad_oe,
                     periph_in, IN_DEF);
        end
        step();
        rst = 1'b0;
        model_clear();
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (cfg_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL abort_after k=%0d got=%b exp=0", k, cfg_rvalid);
            end
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        clk        = 1'b0;
        rst        = 1'b1;
        cfg_req    = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        periph_out = '0;
        periph_oe  = '0;
        pad_in     = '0;
        model_clear();
        test_reset();
        test_outsel_basic();
        test_back_to_back();
        test_outsel_random();
        test_insel_unfiltered();
        test_input_random();
        test_filter();
        test_default();
        test_lock();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
